// File: rtl/sobel_arb_pkg.sv
// Shared types and sizing helpers for the Sobel stream arbiter.
// Frame geometry is turned into beat-counter sizes here so every user agrees.
package sobel_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FWD,
    ST_FLUSH,
    ST_RESULT
  } arb_state_t;

  localparam int CH_W = 1;

  function automatic int calc_npix(input int x_size, input int y_size);
    return x_size * y_size;
  endfunction

  // Beat counter only ever holds 0..NPIX-1, so clog2(NPIX) bits suffice.
  function automatic int calc_cnt_w(input int npix);
    return (npix > 1) ? $clog2(npix) : 1;
  endfunction

endpackage

// File: rtl/sobel_rr_arbiter.sv
// Two-way round-robin picker: a tie goes to the channel that was not served last.
module sobel_rr_arbiter
  import sobel_arb_pkg::*;
(
  input  logic [1:0]      req_i,
  input  logic [CH_W-1:0] last_i,
  output logic [CH_W-1:0] gnt_o,
  output logic            gnt_valid_o
);

  always_comb begin
    gnt_valid_o = |req_i;
    if (&req_i) begin
      gnt_o = ~last_i;
    end else if (req_i[1]) begin
      gnt_o = 1'b1;
    end else begin
      gnt_o = 1'b0;
    end
  end

endmodule

// File: rtl/sobel_stream_arbiter.sv
// Time-shares one Sobel Avalon-ST core between two frame requesters, one frame at a
// time, with frame-length enforcement and a watchdog on the core's result stream.
module sobel_stream_arbiter
  import sobel_arb_pkg::*;
#(
  parameter int IMG_X_SIZE     = 320,
  parameter int IMG_Y_SIZE     = 240,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       csi_clkrst_clk,
  input  logic       csi_clkrst_reset,

  input  logic [7:0] asi_sink0_data,
  input  logic       asi_sink0_startofpacket,
  input  logic       asi_sink0_endofpacket,
  input  logic       asi_sink0_valid,
  output logic       asi_sink0_ready,

  input  logic [7:0] asi_sink1_data,
  input  logic       asi_sink1_startofpacket,
  input  logic       asi_sink1_endofpacket,
  input  logic       asi_sink1_valid,
  output logic       asi_sink1_ready,

  output logic [7:0] aso_core_data,
  output logic       aso_core_startofpacket,
  output logic       aso_core_endofpacket,
  output logic       aso_core_valid,
  input  logic       aso_core_ready,

  input  logic [7:0] asi_core_data,
  input  logic       asi_core_startofpacket,
  input  logic       asi_core_endofpacket,
  input  logic       asi_core_valid,
  output logic       asi_core_ready,

  output logic [7:0] aso_source0_data,
  output logic       aso_source0_startofpacket,
  output logic       aso_source0_endofpacket,
  output logic       aso_source0_valid,
  input  logic       aso_source0_ready,

  output logic [7:0] aso_source1_data,
  output logic       aso_source1_startofpacket,
  output logic       aso_source1_endofpacket,
  output logic       aso_source1_valid,
  input  logic       aso_source1_ready,

  output logic       grant_o,
  output logic       busy_o,
  output logic       err_len_o,
  output logic       err_timeout_o,
  output logic       frame_done_o
);

  localparam int NPIX  = calc_npix(IMG_X_SIZE, IMG_Y_SIZE);
  localparam int CNT_W = calc_cnt_w(NPIX);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NPIX - 1);
  localparam logic [WD_W-1:0]  WD_LIMIT  = WD_W'(TIMEOUT_CYCLES);

  arb_state_t       state_q, state_d;
  logic [CH_W-1:0]  grant_q, grant_d;
  logic [CH_W-1:0]  last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;

  logic [CH_W-1:0] arb_gnt;
  logic            arb_valid;

  logic [7:0] g_data;
  logic       g_sop, g_eop, g_valid, g_src_ready;

  logic [1:0]      sink_ready;
  logic [1:0][7:0] src_data;
  logic [1:0]      src_sop, src_eop, src_valid;
  logic [7:0]      core_data;
  logic            core_sop, core_eop, core_valid, core_ready;
  logic            err_len, err_to, done;

  sobel_rr_arbiter u_rr (
    .req_i       ({asi_sink1_valid && asi_sink1_startofpacket,
                   asi_sink0_valid && asi_sink0_startofpacket}),
    .last_i      (last_q),
    .gnt_o       (arb_gnt),
    .gnt_valid_o (arb_valid)
  );

  assign g_data      = grant_q ? asi_sink1_data          : asi_sink0_data;
  assign g_sop       = grant_q ? asi_sink1_startofpacket : asi_sink0_startofpacket;
  assign g_eop       = grant_q ? asi_sink1_endofpacket   : asi_sink0_endofpacket;
  assign g_valid     = grant_q ? asi_sink1_valid         : asi_sink0_valid;
  assign g_src_ready = grant_q ? aso_source1_ready       : aso_source0_ready;

  always_ff @(posedge csi_clkrst_clk or posedge csi_clkrst_reset) begin
    if (csi_clkrst_reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= CH_W'(1);
      cnt_q   <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      wdog_q  <= wdog_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    wdog_d     = wdog_q;
    sink_ready = '0;
    src_data   = '0;
    src_sop    = '0;
    src_eop    = '0;
    src_valid  = '0;
    core_data  = '0;
    core_sop   = 1'b0;
    core_eop   = 1'b0;
    core_valid = 1'b0;
    core_ready = 1'b0;
    err_len    = 1'b0;
    err_to     = 1'b0;
    done       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Stray mid-packet beats are swallowed; SOP beats wait for the grant.
        sink_ready[0] = asi_sink0_valid && !asi_sink0_startofpacket && !csi_clkrst_reset;
        sink_ready[1] = asi_sink1_valid && !asi_sink1_startofpacket && !csi_clkrst_reset;
        if (arb_valid) begin
          grant_d = arb_gnt;
          state_d = ST_FWD;
        end
      end

      ST_FWD: begin
        core_data          = g_data;
        core_sop           = g_sop;
        core_valid         = g_valid;
        core_eop           = g_eop || (cnt_q == LAST_BEAT);
        sink_ready[grant_q] = aso_core_ready;
        if (g_valid && aso_core_ready) begin
          if (g_eop) begin
            err_len = (cnt_q != LAST_BEAT);
            cnt_d   = '0;
            state_d = ST_RESULT;
          end else if (cnt_q == LAST_BEAT) begin
            err_len = 1'b1;
            cnt_d   = '0;
            state_d = ST_FLUSH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_FLUSH: begin
        sink_ready[grant_q] = 1'b1;
        if (g_valid && g_eop) begin
          state_d = ST_RESULT;
        end
      end

      ST_RESULT: begin
        if (wdog_q == WD_LIMIT) begin
          err_to  = 1'b1;
          last_d  = grant_q;
          wdog_d  = '0;
          state_d = ST_IDLE;
        end else begin
          core_ready         = g_src_ready;
          src_data[grant_q]  = asi_core_data;
          src_sop[grant_q]   = asi_core_startofpacket;
          src_eop[grant_q]   = asi_core_endofpacket;
          src_valid[grant_q] = asi_core_valid;
          if (asi_core_valid && g_src_ready) begin
            wdog_d = '0;
            if (asi_core_endofpacket) begin
              done    = 1'b1;
              last_d  = grant_q;
              state_d = ST_IDLE;
            end
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign asi_sink0_ready           = sink_ready[0];
  assign asi_sink1_ready           = sink_ready[1];
  assign aso_core_data             = core_data;
  assign aso_core_startofpacket    = core_sop;
  assign aso_core_endofpacket      = core_eop;
  assign aso_core_valid            = core_valid;
  assign asi_core_ready            = core_ready;
  assign aso_source0_data          = src_data[0];
  assign aso_source0_startofpacket = src_sop[0];
  assign aso_source0_endofpacket   = src_eop[0];
  assign aso_source0_valid         = src_valid[0];
  assign aso_source1_data          = src_data[1];
  assign aso_source1_startofpacket = src_sop[1];
  assign aso_source1_endofpacket   = src_eop[1];
  assign aso_source1_valid         = src_valid[1];
  assign grant_o                   = grant_q;
  assign busy_o                    = (state_q != ST_IDLE);
  assign err_len_o                 = err_len;
  assign err_timeout_o             = err_to;
  assign frame_done_o              = done;

endmodule

// File: tb/tb_sobel_stream_arbiter.sv
// Self-checking bench: IDLE vector table, directed frame scenarios and randomized
// rounds scored against a frame-level model of arbitration, framing and results.
module tb_sobel_stream_arbiter;

  localparam int NPIX_TB = 8;
  localparam int TO_TB   = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] sink_data [2];
  logic       sink_sop [2], sink_eop [2], sink_valid [2], sink_ready [2];
  logic [7:0] src_data [2];
  logic       src_sop [2], src_eop [2], src_valid [2], src_ready [2];
  logic [7:0] co_data, ci_data;
  logic       co_sop, co_eop, co_valid, co_ready;
  logic       ci_sop, ci_eop, ci_valid, ci_ready;
  logic       grant, busy, err_len, err_to, frame_done;

  sobel_stream_arbiter #(
    .IMG_X_SIZE(4), .IMG_Y_SIZE(2), .TIMEOUT_CYCLES(TO_TB)
  ) dut (
    .csi_clkrst_clk(clk), .csi_clkrst_reset(rst),
    .asi_sink0_data(sink_data[0]), .asi_sink0_startofpacket(sink_sop[0]),
    .asi_sink0_endofpacket(sink_eop[0]), .asi_sink0_valid(sink_valid[0]),
    .asi_sink0_ready(sink_ready[0]),
    .asi_sink1_data(sink_data[1]), .asi_sink1_startofpacket(sink_sop[1]),
    .asi_sink1_endofpacket(sink_eop[1]), .asi_sink1_valid(sink_valid[1]),
    .asi_sink1_ready(sink_ready[1]),
    .aso_core_data(co_data), .aso_core_startofpacket(co_sop),
    .aso_core_endofpacket(co_eop), .aso_core_valid(co_valid), .aso_core_ready(co_ready),
    .asi_core_data(ci_data), .asi_core_startofpacket(ci_sop),
    .asi_core_endofpacket(ci_eop), .asi_core_valid(ci_valid), .asi_core_ready(ci_ready),
    .aso_source0_data(src_data[0]), .aso_source0_startofpacket(src_sop[0]),
    .aso_source0_endofpacket(src_eop[0]), .aso_source0_valid(src_valid[0]),
    .aso_source0_ready(src_ready[0]),
    .aso_source1_data(src_data[1]), .aso_source1_startofpacket(src_sop[1]),
    .aso_source1_endofpacket(src_eop[1]), .aso_source1_valid(src_valid[1]),
    .aso_source1_ready(src_ready[1]),
    .grant_o(grant), .busy_o(busy), .err_len_o(err_len),
    .err_timeout_o(err_to), .frame_done_o(frame_done)
  );

  typedef struct {
    logic v0, s0, v1, s1;
    logic exp_r0, exp_r1, exp_busy, exp_grant;
  } vec_t;

  int checks = 0;
  int failures = 0;

  // Frame-level model: who owns the core, what the core and each source must see.
  int         exp_last;
  logic [7:0] frame_pix [2][$];
  int         sink_idx [2];
  bit         sink_act [2];
  logic [9:0] exp_core [2][$];
  logic [9:0] exp_res [2][$];
  logic [9:0] core_q [$];
  int         order_q [$];
  int         errlen_seen, done_seen, to_seen;
  int         core_mode, src_mode;
  bit         tog;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic logic [40:0] allOutputs();
    return {sink_ready[0], sink_ready[1], co_data, co_sop, co_eop, co_valid, ci_ready,
            src_data[0], src_data[1], src_sop[0], src_sop[1], src_eop[0], src_eop[1],
            src_valid[0], src_valid[1], grant, busy, err_len, err_to, frame_done};
  endfunction

  task automatic idleInputs();
    for (int c = 0; c < 2; c++) begin
      sink_data[c] = '0; sink_sop[c] = 0; sink_eop[c] = 0; sink_valid[c] = 0;
      src_ready[c] = 0;
    end
    co_ready = 0; ci_data = '0; ci_sop = 0; ci_eop = 0; ci_valid = 0;
  endtask

  task automatic modelReset();
    for (int c = 0; c < 2; c++) begin
      frame_pix[c].delete(); exp_core[c].delete(); exp_res[c].delete();
      sink_idx[c] = 0; sink_act[c] = 0;
    end
    core_q.delete(); order_q.delete();
    exp_last = 1;
  endtask

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1;
    idleInputs();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    modelReset();
  endtask

  task automatic applyStimulus(input vec_t v);
    sink_valid[0] = v.v0; sink_sop[0] = v.s0; sink_eop[0] = 0; sink_data[0] = 8'($urandom);
    sink_valid[1] = v.v1; sink_sop[1] = v.s1; sink_eop[1] = 0; sink_data[1] = 8'($urandom);
  endtask

  // A frame of len beats; the core sees at most NPIX of them, EOP on the last one.
  task automatic setupFrame(input int ch, input int len);
    int n;
    frame_pix[ch].delete();
    for (int i = 0; i < len; i++) frame_pix[ch].push_back(8'($urandom));
    sink_idx[ch] = 0;
    sink_act[ch] = 1;
    n = (len < NPIX_TB) ? len : NPIX_TB;
    for (int i = 0; i < n; i++) begin
      exp_core[ch].push_back({frame_pix[ch][i], i == 0, i == n - 1});
      exp_res[ch].push_back({frame_pix[ch][i] ^ 8'h5A, i == 0, i == n - 1});
    end
  endtask

  task automatic stepCycle();
    int owner;
    bit in_res, co_x, ci_x;
    logic [9:0] e;
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      if (sink_act[c]) begin
        sink_valid[c] = (sink_idx[c] == 0) || ($urandom_range(0, 3) != 0);
        sink_data[c]  = frame_pix[c][sink_idx[c]];
        sink_sop[c]   = (sink_idx[c] == 0);
        sink_eop[c]   = (sink_idx[c] == frame_pix[c].size() - 1);
      end else begin
        sink_valid[c] = 0; sink_data[c] = '0; sink_sop[c] = 0; sink_eop[c] = 0;
      end
    end
    co_ready = (core_mode == 1) ? 1'b1 : ($urandom_range(0, 4) != 0);
    ci_valid = (core_q.size() > 0) && (core_mode != 2) &&
               ((core_mode == 1) || ($urandom_range(0, 4) != 0));
    if (core_q.size() > 0) {ci_data, ci_sop, ci_eop} = core_q[0];
    else {ci_data, ci_sop, ci_eop} = '0;
    tog = ~tog;
    src_ready[0] = (src_mode == 2) ? 1'b1 : (src_mode == 1) ? tog : ($urandom_range(0, 4) != 0);
    src_ready[1] = (src_mode == 2) ? 1'b1 : ($urandom_range(0, 4) != 0);

    @(negedge clk);
    owner  = (order_q.size() > 0) ? order_q[0] : -1;
    in_res = 0;
    if (owner >= 0) in_res = (exp_core[owner].size() == 0) && !sink_act[owner];
    co_x = co_valid && co_ready;
    ci_x = ci_valid && ci_ready;

    for (int c = 0; c < 2; c++) begin
      if (sink_act[c] && c != owner) checkOutput("nonowner_sink_ready", sink_ready[c], 0);
      if (sink_act[c] && sink_valid[c] && sink_ready[c]) begin
        if (sink_eop[c]) sink_act[c] = 0;
        sink_idx[c]++;
      end
    end

    if (co_x) begin
      if (owner < 0 || exp_core[owner].size() == 0) begin
        checkOutput("core_unexpected_beat", 1, 0);
      end else begin
        e = exp_core[owner].pop_front();
        checkOutput("core_beat", {co_data, co_sop, co_eop}, e);
      end
      core_q.push_back({co_data ^ 8'h5A, co_sop, co_eop});
    end
    if (err_len) begin
      errlen_seen++;
      checkOutput("errlen_at_core_eop", co_x && co_eop, 1);
    end
    if (ci_x) void'(core_q.pop_front());

    if (in_res) begin
      checkOutput("core_ready_mirror", ci_ready, err_to ? 0 : src_ready[owner]);
      checkOutput("other_source_idle", src_valid[1 - owner], 0);
    end
    for (int c = 0; c < 2; c++) begin
      if (src_valid[c] && src_ready[c]) begin
        if (c != owner || exp_res[c].size() == 0) begin
          checkOutput("source_unexpected_beat", 1, 0);
        end else begin
          e = exp_res[c].pop_front();
          checkOutput(c ? "source1_beat" : "source0_beat", {src_data[c], src_sop[c], src_eop[c]}, e);
          if (e[0]) void'(order_q.pop_front());
        end
      end
    end
    if (frame_done) done_seen++;
    if (err_to) to_seen++;
  endtask

  task automatic runRound(input bit use0, input bit use1, input int len0, input int len1);
    int e_err, e_done, cyc, w;
    bit complete;
    errlen_seen = 0; done_seen = 0; to_seen = 0;
    if (use0 && use1) begin
      w = 1 - exp_last;
      order_q.push_back(w);
      order_q.push_back(1 - w);
      exp_last = 1 - w;
    end else begin
      w = use1 ? 1 : 0;
      order_q.push_back(w);
      exp_last = w;
    end
    if (use0) setupFrame(0, len0);
    if (use1) setupFrame(1, len1);
    e_err  = (use0 && len0 != NPIX_TB) + (use1 && len1 != NPIX_TB);
    e_done = use0 + use1;
    cyc = 0;
    while ((order_q.size() > 0 || sink_act[0] || sink_act[1]) && cyc < 600) begin
      stepCycle();
      cyc++;
    end
    complete = (order_q.size() == 0) && !sink_act[0] && !sink_act[1];
    checkOutput("round_complete", complete, 1);
    checkOutput("errlen_count", errlen_seen, e_err);
    checkOutput("frame_done_count", done_seen, e_done);
    checkOutput("timeout_count", to_seen, 0);
    if (!complete) doReset();
  endtask

  vec_t vecs [9];

  initial begin
    int k, cyc, u;
    logic [40:0] outs;
    vecs[0] = '{0,0,0,0, 0,0,0,0};
    vecs[1] = '{1,0,0,0, 1,0,0,0};
    vecs[2] = '{0,0,1,0, 0,1,0,0};
    vecs[3] = '{1,1,0,0, 0,0,1,0};
    vecs[4] = '{0,0,1,1, 0,0,1,1};
    vecs[5] = '{1,1,1,1, 0,0,1,0};
    vecs[6] = '{1,1,1,0, 0,1,1,0};
    vecs[7] = '{0,1,0,1, 0,0,0,0};
    vecs[8] = '{1,0,1,0, 1,1,0,0};

    core_mode = 0; src_mode = 0; tog = 0;
    idleInputs();
    modelReset();

    // Outputs under reset, with live-looking inputs on every interface.
    rst = 1;
    sink_valid[0] = 1; sink_valid[1] = 1; sink_sop[1] = 1;
    ci_valid = 1; co_ready = 1; src_ready[0] = 1; src_ready[1] = 1;
    repeat (2) @(posedge clk);
    #1;
    outs = allOutputs();
    checkOutput("reset_outputs_lo", outs[31:0], 0);
    checkOutput("reset_outputs_hi", outs[40:32], 0);
    checkOutput("reset_grant", grant, 0);
    checkOutput("reset_busy", busy, 0);

    foreach (vecs[i]) begin
      doReset();
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput("idle_sink0_ready", sink_ready[0], vecs[i].exp_r0);
      checkOutput("idle_sink1_ready", sink_ready[1], vecs[i].exp_r1);
      @(posedge clk); #1;
      checkOutput("idle_busy_next", busy, vecs[i].exp_busy);
      checkOutput("idle_grant_next", grant, vecs[i].exp_grant);
      idleInputs();
    end

    doReset();
    runRound(1, 0, 8, 0);
    doReset();
    runRound(1, 1, 8, 8);
    runRound(1, 1, 8, 8);
    runRound(0, 1, 0, 5);
    runRound(1, 0, 10, 0);

    // Core never answers: watchdog fires on the 17th RESULT cycle (index 16).
    doReset();
    core_mode = 2; src_mode = 2;
    order_q.push_back(0);
    setupFrame(0, 8);
    cyc = 0;
    while (sink_act[0] && cyc < 100) begin stepCycle(); cyc++; end
    checkOutput("timeout_frame_sent", sink_act[0], 0);
    k = 0; to_seen = 0;
    while (to_seen == 0 && k < 40) begin
      stepCycle();
      if (to_seen == 0) k++;
    end
    checkOutput("timeout_cycle", k, TO_TB);
    order_q.delete(); exp_res[0].delete(); core_q.delete();
    exp_last = 0; core_mode = 0; src_mode = 0;
    stepCycle();
    checkOutput("busy_after_timeout", busy, 0);
    runRound(1, 1, 8, 8);

    // Source0 ready toggling every cycle while the core streams continuously.
    doReset();
    src_mode = 1; core_mode = 1;
    runRound(1, 0, 8, 0);
    src_mode = 0; core_mode = 0;

    // Reset in the middle of RESULT.
    doReset();
    core_mode = 2; src_mode = 2;
    order_q.push_back(0);
    setupFrame(0, 8);
    cyc = 0;
    while (sink_act[0] && cyc < 100) begin stepCycle(); cyc++; end
    repeat (3) stepCycle();
    checkOutput("busy_mid_result", busy, 1);
    {ci_data, ci_sop, ci_eop} = core_q[0];
    ci_valid = 1;
    #1;
    checkOutput("result_passthrough_valid", src_valid[0], 1);
    checkOutput("result_passthrough_data", src_data[0], core_q[0][9:2]);
    rst = 1;
    #1;
    outs = allOutputs();
    checkOutput("midreset_outputs_lo", outs[31:0], 0);
    checkOutput("midreset_outputs_hi", outs[40:32], 0);
    @(posedge clk); #1;
    checkOutput("midreset_busy_edge", busy, 0);
    rst = 0;
    idleInputs();
    modelReset();
    core_mode = 0; src_mode = 0;

    for (int r = 0; r < 14; r++) begin
      u = $urandom_range(1, 3);
      runRound(u[0], u[1],
               ($urandom_range(0, 3) == 0) ? $urandom_range(5, 10) : NPIX_TB,
               ($urandom_range(0, 3) == 0) ? $urandom_range(5, 10) : NPIX_TB);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    failures++;
    $display("[TB] FAIL global_time_limit actual=expired required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] time limit");
  end

endmodule
